// File: rtl/runlen_tx.sv
// ---------------------------------------------------------------------------
// runlen_tx - transmit side of the run-length line filter.
//
// Drives a 1-bit line whose level is held for at least MIN_RUN consecutive
// clocks after every change. A downstream filter that needs MIN_RUN equal
// samples therefore never misses a change. Level requests arrive on a
// req/ready handshake. While a run is being held, one further request can be
// buffered.
//
// Parameters
//   MIN_RUN  minimum number of clocks o is held after each change (1..2**CW)
//   CW       width of the run counter
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active high
//   req    in   request to drive level d
//   d      in   requested line level, sampled when req & ready
//   ready  out  a request can be accepted this cycle (no request is buffered)
//   o      out  line output, registered
//   busy   out  a run is being held, or a request is buffered
//   tcnt   out  saturating count of changes of o (RUNLEN_TX_STAT_EN only)
//
// Build option
//   RUNLEN_TX_STAT_EN  adds the 16-bit tcnt port and its counter.
// ---------------------------------------------------------------------------
module runlen_tx #(
    parameter int MIN_RUN = 3,
    parameter int CW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        d,
    output logic        ready,
    output logic        o,
    output logic        busy
`ifdef RUNLEN_TX_STAT_EN
    ,
    output logic [15:0] tcnt
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,   // o stable, minimum run already satisfied
        S_HOLD = 1'b1    // run counter active
    } state_t;

    localparam logic [CW-1:0] RELOAD  = CW'(MIN_RUN - 1);
    // With MIN_RUN == 1 a single clock already satisfies the run, so the
    // HOLD state is never entered.
    localparam bit            HOLD_EN = (MIN_RUN > 1);

    state_t          r_state,  w_state_nxt;
    logic [CW-1:0]   r_cnt,    w_cnt_nxt;
    logic            r_o,      w_o_nxt;
    logic            r_pend_v, w_pend_v_nxt;
    logic            r_pend_d, w_pend_d_nxt;

    logic            w_acc;
    logic            w_start;      // begin a new run this edge
    logic            w_start_lvl;  // level of that new run

    assign ready = !r_pend_v;
    assign w_acc = req && ready;
    assign o     = r_o;
    assign busy  = (r_state == S_HOLD) || r_pend_v;

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_o_nxt      = r_o;
        w_pend_v_nxt = r_pend_v;
        w_pend_d_nxt = r_pend_d;
        w_start      = 1'b0;
        w_start_lvl  = d;

        unique case (r_state)
            S_IDLE: begin
                // A request equal to the current level is simply consumed.
                if (w_acc && (d != r_o)) begin
                    w_start     = 1'b1;
                    w_start_lvl = d;
                end
            end

            S_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (w_acc) begin
                        w_pend_v_nxt = 1'b1;
                        w_pend_d_nxt = d;
                    end
                end else if (r_pend_v) begin
                    // Last hold cycle with a buffered level. ready is low here,
                    // so no new request can collide with it. A buffered level
                    // equal to o is dropped.
                    w_pend_v_nxt = 1'b0;
                    if (r_pend_d != r_o) begin
                        w_start     = 1'b1;
                        w_start_lvl = r_pend_d;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_acc && (d != r_o)) begin
                    // Zero-bubble back-to-back: treated like an IDLE accept.
                    w_start     = 1'b1;
                    w_start_lvl = d;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase

        if (w_start) begin
            w_o_nxt     = w_start_lvl;
            w_cnt_nxt   = RELOAD;
            w_state_nxt = HOLD_EN ? S_HOLD : S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, independent of statement order.
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_o      <= 1'b0;
            r_pend_v <= 1'b0;
            r_pend_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_o      <= w_o_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_pend_d <= w_pend_d_nxt;
        end
    end

`ifdef RUNLEN_TX_STAT_EN
    // Transition counter: one count per edge that changes o, saturating.
    logic [15:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if ((w_o_nxt != r_o) && (r_tcnt != 16'hFFFF)) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    assign tcnt = r_tcnt;
`endif

endmodule

// File: tb/tb_runlen_tx.sv
// ---------------------------------------------------------------------------
// tb_runlen_tx - self-checking bench for runlen_tx (MIN_RUN = 3).
//
// Every cycle, the inputs are driven on the falling edge. A behavioural model
// is stepped with those inputs, and the expected {o, ready, busy} is pushed
// onto a scoreboard queue. After the next rising edge, on the following
// falling edge, the expectation is popped and compared. The model tracks the
// number of edges since the last change of o instead of a countdown.
// A constant vector table covers the basic handshake and the expiry corner
// cases. Hand-written sequences cover reset during a run, continuous
// toggling, and (with RUNLEN_TX_STAT_EN) the transition counter.
// ---------------------------------------------------------------------------
module tb_runlen_tx;

    localparam int MIN_RUN = 3;
    localparam int NVEC    = 24;

    logic clk;
    logic rst;
    logic req;
    logic d;
    logic ready;
    logic o;
    logic busy;
`ifdef RUNLEN_TX_STAT_EN
    logic [15:0] tcnt;
`endif

    runlen_tx #(.MIN_RUN(MIN_RUN), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d     (d),
        .ready (ready),
        .o     (o),
        .busy  (busy)
`ifdef RUNLEN_TX_STAT_EN
        ,
        .tcnt  (tcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic        m_o;
    logic        m_pv;
    logic        m_pd;
    int          m_since;   // edges since the last change of o (saturating)
    logic [15:0] m_tcnt;

    task automatic model_step(input logic rs, input logic rq, input logic dd);
        logic acc;
        logic have;
        logic tgt;
        if (rs) begin
            m_o = 1'b0; m_pv = 1'b0; m_pd = 1'b0; m_since = 15; m_tcnt = '0;
            return;
        end
        acc  = rq && !m_pv;
        have = 1'b0;
        tgt  = 1'b0;
        if (m_since >= MIN_RUN) begin
            if (m_pv) begin
                have = 1'b1; tgt = m_pd; m_pv = 1'b0;
            end else if (acc) begin
                have = 1'b1; tgt = dd;
            end
            if (have && (tgt != m_o)) begin
                m_o = tgt;
                m_since = 1;
                if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
            end else begin
                m_since = (m_since >= 15) ? 15 : m_since + 1;
            end
        end else begin
            if (acc) begin
                m_pv = 1'b1; m_pd = dd;
            end
            m_since = (m_since >= 15) ? 15 : m_since + 1;
        end
    endtask

    // ---------------- scoreboard-driven cycle ----------------
    logic [2:0] sb_q[$];

    task automatic drive_cycle(input logic rs, input logic rq, input logic dd, input string tag);
        logic [2:0] e;
        rst = rs; req = rq; d = dd;
        model_step(rs, rq, dd);
        sb_q.push_back({m_o, !m_pv, (m_since <= MIN_RUN) || m_pv});
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb_q.pop_front();
            check(tag, {13'd0, o, ready, busy}, {13'd0, e});
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       req;
        logic       d;
        logic [2:0] exp;   // {o, ready, busy} after the edge
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        int   last_chg;
        int   n_chg;
        logic prev_o;

        // Row i: inputs during cycle i, outputs expected in cycle i+1.
        vecs[0]  = '{1'b1, 1'b1, 3'b111};  // accept 1: o changes, HOLD
        vecs[1]  = '{1'b1, 1'b0, 3'b101};  // 0 buffered, ready drops
        vecs[2]  = '{1'b0, 1'b0, 3'b101};  // last hold cycle
        vecs[3]  = '{1'b0, 1'b0, 3'b011};  // buffered 0 applied at expiry
        vecs[4]  = '{1'b0, 1'b0, 3'b011};
        vecs[5]  = '{1'b0, 1'b0, 3'b011};
        vecs[6]  = '{1'b0, 1'b0, 3'b010};  // back to IDLE
        vecs[7]  = '{1'b1, 1'b0, 3'b010};  // same level: consumed, no change
        vecs[8]  = '{1'b1, 1'b1, 3'b111};
        vecs[9]  = '{1'b1, 1'b1, 3'b101};  // buffered level equals o
        vecs[10] = '{1'b0, 1'b0, 3'b101};
        vecs[11] = '{1'b0, 1'b0, 3'b110};  // dropped silently, IDLE
        vecs[12] = '{1'b0, 1'b0, 3'b110};
        vecs[13] = '{1'b1, 1'b0, 3'b011};  // busy for exactly 3 cycles
        vecs[14] = '{1'b0, 1'b0, 3'b011};
        vecs[15] = '{1'b0, 1'b0, 3'b011};
        vecs[16] = '{1'b0, 1'b0, 3'b010};
        vecs[17] = '{1'b1, 1'b1, 3'b111};
        vecs[18] = '{1'b0, 1'b0, 3'b111};
        vecs[19] = '{1'b0, 1'b0, 3'b111};
        vecs[20] = '{1'b1, 1'b0, 3'b011};  // accept on last hold cycle, no bubble
        vecs[21] = '{1'b0, 1'b0, 3'b011};
        vecs[22] = '{1'b0, 1'b0, 3'b011};
        vecs[23] = '{1'b0, 1'b0, 3'b010};

        rst = 1'b1; req = 1'b0; d = 1'b0;
        @(negedge clk);

        // 1: reset values
        drive_cycle(1'b1, 1'b0, 1'b0, "reset0");
        drive_cycle(1'b1, 1'b0, 1'b0, "reset1");
        check("reset_const", {13'd0, o, ready, busy}, 16'b010);

        // table
        for (int i = 0; i < NVEC; i++) begin
            drive_cycle(1'b0, vecs[i].req, vecs[i].d, $sformatf("vec%0d_sb", i));
            check($sformatf("vec%0d", i), {13'd0, o, ready, busy}, {13'd0, vecs[i].exp});
        end

        // 1b: reset pulse while busy with a buffered request
        drive_cycle(1'b0, 1'b1, 1'b1, "midrst_a");
        drive_cycle(1'b0, 1'b1, 1'b0, "midrst_b");
        check("midrst_pending", {15'd0, ready}, 16'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, "midrst_rst");
        check("midrst_after", {13'd0, o, ready, busy}, 16'b010);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, $sformatf("midrst_idle%0d", i));
            check($sformatf("midrst_discard%0d", i), {13'd0, o, ready, busy}, 16'b010);
        end

        // 4: req held high, d toggling every cycle
        last_chg = -1;
        n_chg    = 0;
        prev_o   = o;
        for (int k = 0; k < 20; k++) begin
            drive_cycle(1'b0, 1'b1, (k % 2 == 0), $sformatf("toggle%0d", k));
            if (o !== prev_o) begin
                if (last_chg >= 0) check($sformatf("run_len_%0d", k), 16'(k - last_chg), 16'(MIN_RUN));
                last_chg = k;
                n_chg++;
                prev_o = o;
            end
        end
        check("toggle_changes", 16'(n_chg), 16'd7);
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 1'b0, $sformatf("settle%0d", i));
        check("settle_idle", {14'd0, ready, busy}, 16'b10);

`ifdef RUNLEN_TX_STAT_EN
        // 6: transition counter
        drive_cycle(1'b1, 1'b0, 1'b0, "stat_rst");
        check("tcnt_reset", tcnt, 16'd0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, (i % 2 == 0), $sformatf("stat_chg%0d", i));
            for (int j = 0; j < 3; j++) drive_cycle(1'b0, 1'b0, 1'b0, $sformatf("stat_w%0d_%0d", i, j));
        end
        check("tcnt_five", tcnt, 16'd5);
        check("tcnt_model", tcnt, m_tcnt);
        force dut.r_tcnt = 16'hFFFF;
        #1;
        release dut.r_tcnt;
        m_tcnt = 16'hFFFF;
        drive_cycle(1'b0, 1'b1, ~o, "stat_sat_chg");
        check("tcnt_saturate", tcnt, 16'hFFFF);
        for (int j = 0; j < 3; j++) drive_cycle(1'b0, 1'b0, 1'b0, $sformatf("stat_sat_w%0d", j));
        check("tcnt_saturate_hold", tcnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
